// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking-network packet path.
package snn_pkg;

    localparam int unsigned ADDR_WIDTH   = 12;
    localparam int unsigned PACKET_WIDTH = 2 * ADDR_WIDTH;

    // Packet layout: {origin, destination}
    localparam int unsigned PKT_ORIGIN_MSB = PACKET_WIDTH - 1;
    localparam int unsigned PKT_ORIGIN_LSB = ADDR_WIDTH;
    localparam int unsigned PKT_DEST_MSB   = ADDR_WIDTH - 1;
    localparam int unsigned PKT_DEST_LSB   = 0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StHold = 2'd2
    } disp_state_e;

endpackage

// File: rtl/packet_fifo.sv
// Parameterised synchronous FIFO with first-word fall-through read data.
module packet_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Requests beyond full/empty are ignored so callers cannot corrupt state.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
        count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/spike_packet_dispatcher.sv
// Buffers incoming spike packets and delivers them to the local accumulators
// as a one-hot strobe plus origin address, one per cycle, pausing across clear.
module spike_packet_dispatcher #(
    parameter int unsigned NUM_NEURONS  = 10,
    parameter int unsigned ADDR_WIDTH   = snn_pkg::ADDR_WIDTH,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned BASE_ADDRESS = 0,
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1,
    localparam int unsigned IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [2*ADDR_WIDTH-1:0] packet,
    input  logic                    packet_valid,
    output logic                    packet_ready,
    output logic [NUM_NEURONS-1:0]  dispatch_strobe,
    output logic [ADDR_WIDTH-1:0]   dispatch_source_address,
    output logic [CNT_W-1:0]        fifo_count,
    output logic [7:0]              dropped_count
);

    import snn_pkg::*;

    localparam int unsigned ENTRY_W = ADDR_WIDTH + IDX_W;

    disp_state_e            state_q, state_d;
    logic [NUM_NEURONS-1:0] strobe_q, strobe_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [7:0]             dropped_q, dropped_d;

    logic [ADDR_WIDTH-1:0]  pkt_origin, pkt_dest;
    logic [ADDR_WIDTH:0]    dest_off;
    logic                   in_range, accept;
    logic [IDX_W-1:0]       local_idx;
    logic [ENTRY_W-1:0]     fifo_wdata, fifo_rdata;
    logic                   fifo_full, fifo_empty;
    logic                   launch;
    logic [ADDR_WIDTH-1:0]  head_origin;
    logic [IDX_W-1:0]       head_idx;
    logic [NUM_NEURONS-1:0] head_onehot;

    assign pkt_origin = packet[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign pkt_dest   = packet[ADDR_WIDTH-1:0];

    // Extra MSB of the offset is the borrow: set when dest is below the base.
    assign dest_off  = {1'b0, pkt_dest} - (ADDR_WIDTH + 1)'(BASE_ADDRESS);
    assign in_range  = !dest_off[ADDR_WIDTH]
                       && (dest_off[ADDR_WIDTH-1:0] < ADDR_WIDTH'(NUM_NEURONS));
    assign local_idx = dest_off[IDX_W-1:0];

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign packet_ready = !fifo_full;
    assign accept       = packet_valid && packet_ready;
    assign fifo_wdata   = {pkt_origin, local_idx};

    assign head_origin = fifo_rdata[IDX_W +: ADDR_WIDTH];
    assign head_idx    = fifo_rdata[IDX_W-1:0];

    packet_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (reset),
        .push_i  (accept && in_range),
        .pop_i   (launch),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Decode the head entry's local index into the accumulator select.
    always_comb begin
        head_onehot = '0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            head_onehot[i] = (head_idx == IDX_W'(i));
        end
    end

    // Delivery FSM: a launch pops the head and registers its strobe at the same edge.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && !clear) begin
                    state_d = StSend;
                    launch  = 1'b1;
                end
            end
            StSend: begin
                if (clear) begin
                    state_d = StHold;
                end else if (!fifo_empty) begin
                    launch = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (!clear) begin
                    if (!fifo_empty) begin
                        state_d = StSend;
                        launch  = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Strobe is a single-cycle pulse; the address holds between strobes.
    always_comb begin
        strobe_d = '0;
        addr_d   = addr_q;
        if (launch) begin
            strobe_d = head_onehot;
            addr_d   = head_origin;
        end
    end

    // Out-of-range packets complete the handshake but are only counted.
    always_comb begin
        dropped_d = dropped_q;
        if (accept && !in_range && (dropped_q != 8'hFF)) begin
            dropped_d = dropped_q + 8'd1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            strobe_q  <= '0;
            addr_q    <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            addr_q    <= addr_d;
            dropped_q <= dropped_d;
        end
    end

    assign dispatch_strobe         = strobe_q;
    assign dispatch_source_address = addr_q;
    assign dropped_count           = dropped_q;

endmodule
